// File: rtl/ifft_butterfly_dif_pipe.sv
// Pipelined radix-2 DIF butterfly for the inverse transform: X0 = A0 + A1, X1 = (A0 - A1) * conj(W).
// Define IFFT_BFLY_SCALE_EN to halve sum and diff in the first stage (1/N normalisation over all stages).
module ifft_butterfly_dif_pipe #(
  parameter int WIDTH    = 32,
  parameter int Q_LENGTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    di_valid,
  output logic                    di_ready,
  input  logic signed [WIDTH-1:0] di_real0,
  input  logic signed [WIDTH-1:0] di_img0,
  input  logic signed [WIDTH-1:0] di_real1,
  input  logic signed [WIDTH-1:0] di_img1,
  input  logic signed [WIDTH-1:0] W_N_real,
  input  logic signed [WIDTH-1:0] W_N_img,
  output logic                    do_valid,
  input  logic                    do_ready,
  output logic signed [WIDTH-1:0] do_real0,
  output logic signed [WIDTH-1:0] do_img0,
  output logic signed [WIDTH-1:0] do_real1,
  output logic signed [WIDTH-1:0] do_img1
);

  localparam int PW = 2 * WIDTH;

  logic advance;
  logic load1;
  logic load2;
  logic load3;

  // Full-pipeline stall: nothing moves while the output beat waits to be taken.
  assign advance  = !do_valid || do_ready;
  assign di_ready = advance;

  logic s1_valid;
  logic s2_valid;
  assign load1 = advance && di_valid;
  assign load2 = advance && s1_valid;
  assign load3 = advance && s2_valid;

  logic signed [WIDTH-1:0] sum_re_n, sum_im_n, diff_re_n, diff_im_n;

`ifdef IFFT_BFLY_SCALE_EN
  logic signed [WIDTH:0] sum_re_w, sum_im_w, diff_re_w, diff_im_w;

  // One guard bit absorbs the carry, then the LSB is dropped (floor of x/2).
  assign sum_re_w  = {di_real0[WIDTH-1], di_real0} + {di_real1[WIDTH-1], di_real1};
  assign sum_im_w  = {di_img0[WIDTH-1], di_img0} + {di_img1[WIDTH-1], di_img1};
  assign diff_re_w = {di_real0[WIDTH-1], di_real0} - {di_real1[WIDTH-1], di_real1};
  assign diff_im_w = {di_img0[WIDTH-1], di_img0} - {di_img1[WIDTH-1], di_img1};
  assign sum_re_n  = sum_re_w[WIDTH:1];
  assign sum_im_n  = sum_im_w[WIDTH:1];
  assign diff_re_n = diff_re_w[WIDTH:1];
  assign diff_im_n = diff_im_w[WIDTH:1];
`else
  assign sum_re_n  = di_real0 + di_real1;
  assign sum_im_n  = di_img0 + di_img1;
  assign diff_re_n = di_real0 - di_real1;
  assign diff_im_n = di_img0 - di_img1;
`endif

  logic signed [WIDTH-1:0] s1_sum_re, s1_sum_im, s1_dr, s1_di, s1_wr, s1_wi;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_sum_re <= '0;
      s1_sum_im <= '0;
      s1_dr     <= '0;
      s1_di     <= '0;
      s1_wr     <= '0;
      s1_wi     <= '0;
    end else if (advance) begin
      s1_valid <= di_valid;
      if (load1) begin
        s1_sum_re <= sum_re_n;
        s1_sum_im <= sum_im_n;
        s1_dr     <= diff_re_n;
        s1_di     <= diff_im_n;
        s1_wr     <= W_N_real;
        s1_wi     <= W_N_img;
      end
    end
  end

  // Operands widened to the product width so every product is exact.
  logic signed [PW-1:0] dr_x, di_x, wr_x, wi_x;
  assign dr_x = {{WIDTH{s1_dr[WIDTH-1]}}, s1_dr};
  assign di_x = {{WIDTH{s1_di[WIDTH-1]}}, s1_di};
  assign wr_x = {{WIDTH{s1_wr[WIDTH-1]}}, s1_wr};
  assign wi_x = {{WIDTH{s1_wi[WIDTH-1]}}, s1_wi};

  logic signed [WIDTH-1:0] s2_sum_re, s2_sum_im;
  logic signed [PW-1:0]    p_rr, p_ii, p_ir, p_ri;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      s2_sum_re <= '0;
      s2_sum_im <= '0;
      p_rr      <= '0;
      p_ii      <= '0;
      p_ir      <= '0;
      p_ri      <= '0;
    end else if (advance) begin
      s2_valid <= s1_valid;
      if (load2) begin
        s2_sum_re <= s1_sum_re;
        s2_sum_im <= s1_sum_im;
        p_rr      <= dr_x * wr_x;
        p_ii      <= di_x * wi_x;
        p_ir      <= di_x * wr_x;
        p_ri      <= dr_x * wi_x;
      end
    end
  end

  // conj(W): re = dr*wr + di*wi, im = di*wr - dr*wi; selecting bits from Q_LENGTH up is a floor shift.
  logic signed [PW:0] re_full, im_full;
  assign re_full = {p_rr[PW-1], p_rr} + {p_ii[PW-1], p_ii};
  assign im_full = {p_ir[PW-1], p_ir} - {p_ri[PW-1], p_ri};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      do_valid <= 1'b0;
      do_real0 <= '0;
      do_img0  <= '0;
      do_real1 <= '0;
      do_img1  <= '0;
    end else if (advance) begin
      do_valid <= s2_valid;
      if (load3) begin
        do_real0 <= s2_sum_re;
        do_img0  <= s2_sum_im;
        do_real1 <= re_full[Q_LENGTH +: WIDTH];
        do_img1  <= im_full[Q_LENGTH +: WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_ifft_butterfly_dif_pipe.sv
// Self-checking bench for ifft_butterfly_dif_pipe: directed twiddle cases, backpressure, reset, full-rate streaming.
module tb_ifft_butterfly_dif_pipe;
  typedef logic signed [127:0] big_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic di_valid = 1'b0;
  logic di_ready;
  logic signed [31:0] di_real0 = '0, di_img0 = '0, di_real1 = '0, di_img1 = '0;
  logic signed [31:0] W_N_real = '0, W_N_img = '0;
  logic do_valid;
  logic do_ready = 1'b1;
  logic signed [31:0] do_real0, do_img0, do_real1, do_img1;

  int n_checks = 0;
  int n_pass = 0;
  logic [127:0] exp_q[$];

  ifft_butterfly_dif_pipe #(.WIDTH(32), .Q_LENGTH(16)) dut (
    .clk(clk), .rst(rst),
    .di_valid(di_valid), .di_ready(di_ready),
    .di_real0(di_real0), .di_img0(di_img0), .di_real1(di_real1), .di_img1(di_img1),
    .W_N_real(W_N_real), .W_N_img(W_N_img),
    .do_valid(do_valid), .do_ready(do_ready),
    .do_real0(do_real0), .do_img0(do_img0), .do_real1(do_real1), .do_img1(do_img1)
  );

  always #5 clk = ~clk;

`ifdef IFFT_BFLY_SCALE_EN
  localparam logic [127:0] ID_EXP = {32'h00020000, 32'h00000000, 32'h00010000, 32'h00010000};
  localparam logic [127:0] NJ_EXP = {32'h00020000, 32'h00000000, 32'hFFFF0000, 32'h00010000};
`else
  localparam logic [127:0] ID_EXP = {32'h00040000, 32'h00000000, 32'h00020000, 32'h00020000};
  localparam logic [127:0] NJ_EXP = {32'h00040000, 32'h00000000, 32'hFFFE0000, 32'h00020000};
`endif

  function automatic big_t sx(input logic [31:0] v);
    return {{96{v[31]}}, v};
  endfunction

  // Exact sum/difference reduced to the 32-bit stage value: halved (floor) when scaling, else wrapped.
  function automatic big_t stage_val(input big_t v);
    big_t h;
`ifdef IFFT_BFLY_SCALE_EN
    h = v >>> 1;
`else
    h = v;
`endif
    return sx(h[31:0]);
  endfunction

  function automatic logic [127:0] ref_model(input logic [31:0] a0r, a0i, a1r, a1i, wr, wi);
    big_t sr, si, dr, di, re, im;
    sr = stage_val(sx(a0r) + sx(a1r));
    si = stage_val(sx(a0i) + sx(a1i));
    dr = stage_val(sx(a0r) - sx(a1r));
    di = stage_val(sx(a0i) - sx(a1i));
    re = (dr * sx(wr) + di * sx(wi)) >>> 16;
    im = (di * sx(wr) - dr * sx(wi)) >>> 16;
    return {sr[31:0], si[31:0], re[31:0], im[31:0]};
  endfunction

  function automatic logic [127:0] cur_in_exp();
    return ref_model(di_real0, di_img0, di_real1, di_img1, W_N_real, W_N_img);
  endfunction

  task automatic set_beat(input logic [31:0] a0r, a0i, a1r, a1i, wr, wi);
    di_real0 = a0r; di_img0 = a0i; di_real1 = a1r; di_img1 = a1i; W_N_real = wr; W_N_img = wi;
  endtask

  task automatic rand_beat();
    set_beat($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    rand_beat();
    di_valid = 1'b1;
    @(posedge clk); #4;
    n_checks++;
    if (do_valid !== 1'b0) $display("FAIL reset_do_valid: got %b want 0", do_valid); else n_pass++;
    n_checks++;
    if ({do_real0, do_img0, do_real1, do_img1} !== 128'h0)
      $display("FAIL reset_do_data: got %h want 0", {do_real0, do_img0, do_real1, do_img1});
    else n_pass++;
    n_checks++;
    if (di_ready !== 1'b1) $display("FAIL reset_di_ready: got %b want 1", di_ready); else n_pass++;
    @(posedge clk); #1;
    di_valid = 1'b0;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
    end
    n_checks++;
    if (do_valid !== 1'b0) $display("FAIL reset_idle_valid: got %b want 0", do_valid); else n_pass++;
  endtask

  task automatic test_identity();
    @(posedge clk); #1;
    set_beat(32'h00030000, 32'h00010000, 32'h00010000, 32'hFFFF0000, 32'h00010000, 32'h0);
    di_valid = 1'b1;
    do_ready = 1'b1;
    #3;
    n_checks++;
    if (di_ready !== 1'b1) $display("FAIL ident_accept: got di_ready %b want 1", di_ready); else n_pass++;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      di_valid = 1'b0;
      rand_beat();
      #3;
      n_checks++;
      if (do_valid !== (k == 3)) $display("FAIL ident_latency_c%0d: got do_valid %b want %b", k, do_valid, (k == 3));
      else n_pass++;
    end
    n_checks++;
    if ({do_real0, do_img0, do_real1, do_img1} !== ID_EXP)
      $display("FAIL ident_data: got %h want %h", {do_real0, do_img0, do_real1, do_img1}, ID_EXP);
    else n_pass++;
  endtask

  task automatic test_neg_j();
    int cyc;
    @(posedge clk); #1;
    set_beat(32'h00030000, 32'h00010000, 32'h00010000, 32'hFFFF0000, 32'h0, 32'hFFFF0000);
    di_valid = 1'b1;
    @(posedge clk); #1;
    di_valid = 1'b0;
    cyc = 0;
    #3;
    while (!do_valid && cyc < 10) begin
      @(posedge clk); #4;
      cyc++;
    end
    n_checks++;
    if (!do_valid) $display("FAIL negj_timeout: got no output want one within 10 cycles");
    else if ({do_real0, do_img0, do_real1, do_img1} !== NJ_EXP)
      $display("FAIL negj_data: got %h want %h", {do_real0, do_img0, do_real1, do_img1}, NJ_EXP);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [31:0] beats[8][6];
    logic [127:0] snap, want;
    int sent = 0, got = 0, cyc = 0, stall = 0;
    bit seen = 1'b0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 6; j++) beats[i][j] = $urandom;
    exp_q.delete();
    while (got < 8 && cyc < 80) begin
      @(posedge clk); #1;
      do_ready = !(seen && stall < 5);
      di_valid = (sent < 8);
      if (sent < 8) set_beat(beats[sent][0], beats[sent][1], beats[sent][2], beats[sent][3], beats[sent][4], beats[sent][5]);
      else rand_beat();
      #3;
      if (!do_ready) begin
        n_checks++;
        if (di_ready !== 1'b0 || do_valid !== 1'b1)
          $display("FAIL bp_stall_c%0d: got di_ready %b do_valid %b want 0 1", stall, di_ready, do_valid);
        else n_pass++;
        if (stall == 0) snap = {do_real0, do_img0, do_real1, do_img1};
        else begin
          n_checks++;
          if ({do_real0, do_img0, do_real1, do_img1} !== snap)
            $display("FAIL bp_stable_c%0d: got %h want %h", stall, {do_real0, do_img0, do_real1, do_img1}, snap);
          else n_pass++;
        end
        stall++;
      end
      if (do_valid && do_ready) begin
        want = (exp_q.size() != 0) ? exp_q.pop_front() : 128'hx;
        n_checks++;
        if ({do_real0, do_img0, do_real1, do_img1} !== want)
          $display("FAIL bp_beat%0d: got %h want %h", got, {do_real0, do_img0, do_real1, do_img1}, want);
        else n_pass++;
        got++;
        seen = 1'b1;
      end
      if (di_valid && di_ready) begin
        exp_q.push_back(cur_in_exp());
        sent++;
      end
      cyc++;
    end
    n_checks++;
    if (got != 8 || stall != 5) $display("FAIL bp_count: got %0d beats %0d stalls want 8 beats 5 stalls", got, stall);
    else n_pass++;
    di_valid = 1'b0;
    do_ready = 1'b1;
  endtask

  task automatic test_reset_midstream();
    logic [127:0] want;
    int cyc, got;
    exp_q.delete();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      rand_beat();
      di_valid = 1'b1;
    end
    @(posedge clk); #1;
    di_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (do_valid !== 1'b0) $display("FAIL rstmid_valid: got %b want 0", do_valid); else n_pass++;
    n_checks++;
    if ({do_real0, do_img0, do_real1, do_img1} !== 128'h0)
      $display("FAIL rstmid_data: got %h want 0", {do_real0, do_img0, do_real1, do_img1});
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    got = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #4;
      if (do_valid) got++;
    end
    n_checks++;
    if (got != 0) $display("FAIL rstmid_ghost: got %0d output beats want 0", got); else n_pass++;
    @(posedge clk); #1;
    rand_beat();
    want = cur_in_exp();
    di_valid = 1'b1;
    @(posedge clk); #1;
    di_valid = 1'b0;
    cyc = 0;
    #3;
    while (!do_valid && cyc < 10) begin
      @(posedge clk); #4;
      cyc++;
    end
    n_checks++;
    if (!do_valid) $display("FAIL rstmid_timeout: got no output want one within 10 cycles");
    else if ({do_real0, do_img0, do_real1, do_img1} !== want)
      $display("FAIL rstmid_data_after: got %h want %h", {do_real0, do_img0, do_real1, do_img1}, want);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_full_rate();
    logic [127:0] want;
    int sent = 0, got = 0, cyc = 0, first = -1, last = -1, busy = 0;
    exp_q.delete();
    do_ready = 1'b1;
    while (got < 16 && cyc < 40) begin
      @(posedge clk); #1;
      di_valid = (sent < 16);
      if (sent == 5) set_beat(32'h7FFF0000, 32'h7FFF0000, 32'h7FFF0000, 32'h7FFF0000, 32'h00010000, 32'h0);
      else rand_beat();
      #3;
      if (di_valid && di_ready !== 1'b1) busy++;
      if (do_valid) begin
        want = (exp_q.size() != 0) ? exp_q.pop_front() : 128'hx;
        n_checks++;
        if ({do_real0, do_img0, do_real1, do_img1} !== want)
          $display("FAIL full_beat%0d: got %h want %h", got, {do_real0, do_img0, do_real1, do_img1}, want);
        else n_pass++;
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      if (di_valid && di_ready) begin
        exp_q.push_back(cur_in_exp());
        sent++;
      end
      cyc++;
    end
    di_valid = 1'b0;
    n_checks++;
    if (got != 16 || last - first != 15 || busy != 0)
      $display("FAIL full_rate: got %0d beats over %0d cycles, %0d not-ready want 16 over 16, 0", got, last - first + 1, busy);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_identity();
    test_neg_j();
    test_backpressure();
    test_reset_midstream();
    test_full_rate();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1);
  end
endmodule
